// File: rtl/test_sequencer_if.sv
// Run-control bus between a test harness and the test sequencer.
// The harness side is the master and the sequencer side is the slave.
interface test_sequencer_if;
    logic        i_start;
    logic        i_abort;
    logic        i_ack;
    logic [31:0] i_num_samples;
    logic [31:0] i_data_ctr;
    logic [31:0] i_event_ctr;
    logic        o_enable;
    logic        o_freeze;
    logic        o_busy;
    logic        o_done;
    logic        o_aborted;
    logic        o_pass;
    logic [31:0] o_result_data;
    logic [31:0] o_result_events;
    logic [2:0]  o_state;

    modport master (
        output i_start, i_abort, i_ack, i_num_samples, i_data_ctr, i_event_ctr,
        input  o_enable, o_freeze, o_busy, o_done, o_aborted, o_pass,
        input  o_result_data, o_result_events, o_state
    );

    modport slave (
        input  i_start, i_abort, i_ack, i_num_samples, i_data_ctr, i_event_ctr,
        output o_enable, o_freeze, o_busy, o_done, o_aborted, o_pass,
        output o_result_data, o_result_events, o_state
    );
endinterface

// File: rtl/test_sequencer.sv
// Run sequencer: enables the DUT for N samples, drains the pipeline, freezes the
// monitors and captures data/event counts relative to a baseline taken at start.
module test_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic             clk_dut,
    input  logic             reset,
    test_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] sample_cnt_r;
    logic [31:0] sample_cnt_nxt_s;
    logic [7:0]  drain_cnt_r;
    logic [7:0]  drain_cnt_nxt_s;
    logic [31:0] base_data_r;
    logic [31:0] base_data_nxt_s;
    logic [31:0] base_event_r;
    logic [31:0] base_event_nxt_s;
    logic        aborted_r;
    logic        aborted_nxt_s;
    logic        pass_r;
    logic        pass_nxt_s;
    logic [31:0] res_data_r;
    logic [31:0] res_data_nxt_s;
    logic [31:0] res_events_r;
    logic [31:0] res_events_nxt_s;
    logic [31:0] diff_data_s;
    logic [31:0] diff_events_s;
    logic        enable_r;
    logic        freeze_r;
    logic        busy_r;
    logic        done_r;

    // Unsigned subtraction makes the counts correct across counter wrap.
    assign diff_data_s   = bus.i_data_ctr - base_data_r;
    assign diff_events_s = bus.i_event_ctr - base_event_r;

    // Next-state and datapath decode.
    always_comb begin
        state_nxt_s      = state_r;
        sample_cnt_nxt_s = sample_cnt_r;
        drain_cnt_nxt_s  = drain_cnt_r;
        base_data_nxt_s  = base_data_r;
        base_event_nxt_s = base_event_r;
        aborted_nxt_s    = aborted_r;
        pass_nxt_s       = pass_r;
        res_data_nxt_s   = res_data_r;
        res_events_nxt_s = res_events_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_abort && (bus.i_num_samples != 32'd0)) begin
                    state_nxt_s      = ST_RUN;
                    sample_cnt_nxt_s = bus.i_num_samples;
                    base_data_nxt_s  = bus.i_data_ctr;
                    base_event_nxt_s = bus.i_event_ctr;
                    aborted_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Down-counter holds the remaining RUN cycles, so N = 2^32-1 cannot overflow.
                if (bus.i_abort) begin
                    state_nxt_s      = ST_DRAIN;
                    aborted_nxt_s    = 1'b1;
                    sample_cnt_nxt_s = 32'd0;
                    drain_cnt_nxt_s  = DRAIN_LOAD;
                end else if (sample_cnt_r <= 32'd1) begin
                    state_nxt_s      = ST_DRAIN;
                    sample_cnt_nxt_s = 32'd0;
                    drain_cnt_nxt_s  = DRAIN_LOAD;
                end else begin
                    sample_cnt_nxt_s = sample_cnt_r - 32'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r <= 8'd1) begin
                    state_nxt_s     = ST_CAPTURE;
                    drain_cnt_nxt_s = 8'd0;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - 8'd1;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s      = ST_DONE;
                res_data_nxt_s   = diff_data_s;
                res_events_nxt_s = diff_events_s;
                pass_nxt_s       = (diff_events_s == 32'd0) && !aborted_r;
            end
            ST_DONE: begin
                if (bus.i_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, baselines and results.
    always_ff @(posedge clk_dut or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            sample_cnt_r <= 32'd0;
            drain_cnt_r  <= 8'd0;
            base_data_r  <= 32'd0;
            base_event_r <= 32'd0;
            aborted_r    <= 1'b0;
            pass_r       <= 1'b0;
            res_data_r   <= 32'd0;
            res_events_r <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            sample_cnt_r <= sample_cnt_nxt_s;
            drain_cnt_r  <= drain_cnt_nxt_s;
            base_data_r  <= base_data_nxt_s;
            base_event_r <= base_event_nxt_s;
            aborted_r    <= aborted_nxt_s;
            pass_r       <= pass_nxt_s;
            res_data_r   <= res_data_nxt_s;
            res_events_r <= res_events_nxt_s;
        end
    end

    // Control outputs are registered from the next state so they align with state_r.
    always_ff @(posedge clk_dut or negedge reset) begin
        if (!reset) begin
            enable_r <= 1'b0;
            freeze_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            enable_r <= (state_nxt_s == ST_RUN);
            freeze_r <= (state_nxt_s == ST_CAPTURE) || (state_nxt_s == ST_DONE);
            busy_r   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN) ||
                        (state_nxt_s == ST_CAPTURE);
            done_r   <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.o_enable        = enable_r;
    assign bus.o_freeze        = freeze_r;
    assign bus.o_busy          = busy_r;
    assign bus.o_done          = done_r;
    assign bus.o_aborted       = aborted_r;
    assign bus.o_pass          = pass_r;
    assign bus.o_result_data   = res_data_r;
    assign bus.o_result_events = res_events_r;
    assign bus.o_state         = state_r;

endmodule
